instr_fetch: RTL
================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, meaning instruction buffer entries.
REQ-002 The block SHALL have parameter TIMEOUT, default 16, meaning imem_req cycles without imem_ack before error.
REQ-003 The block SHALL have parameter BEQ_OPCODE, default 6'b000100, meaning the opcode that asserts branch_out.
REQ-004 The block SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-006 The block SHALL have port pc_in, input, 32, meaning the current PC from the PC unit (its p_out).
REQ-007 The block SHALL have port pc_advance, output, 1, meaning a one-cycle pulse telling the PC unit to load its next value.
REQ-008 The block SHALL have these memory ports: imem_req out 1 (read request); imem_addr out 32 (read address); imem_ack in 1 (data valid); imem_rdata in 32 (read data).
REQ-009 The block SHALL have these decode-side ports: instr_out out 32 (buffer head word); instr_pc out 32 (head PC); instr_valid out 1 (head valid); instr_ready in 1 (consumer accepts).
REQ-010 The block SHALL have these PC-unit feedback ports: imm_out out 16 (head word [15:0], drives PC instruct); branch_out out 1 (drives PC control).
REQ-011 The block SHALL have these control and status ports: flush in 1 (branch redirect, discard buffered and in-flight words); fetch_err out 1 (sticky timeout flag).

Function
REQ-012 The FSM SHALL have states IDLE, REQ, DROP and ERR.
REQ-013 IDLE SHALL go to REQ on the next edge when the buffer has a free entry and flush=0.
REQ-014 On entering REQ the block SHALL latch pc_in; imem_addr SHALL hold that value and imem_req SHALL be 1 until imem_ack is seen.
REQ-015 When imem_ack=1 in REQ, the block SHALL push {imem_rdata, latched PC}, pulse pc_advance for exactly that cycle, and return to IDLE.
REQ-016 The earliest next request SHALL be one cycle after the pc_advance pulse, giving at most one fetch per 2 cycles.
REQ-017 Latency SHALL be: ack in cycle N -> instr_valid=1 in cycle N+1.
REQ-018 A pop SHALL occur when instr_valid and instr_ready are both 1; push and pop in the same cycle SHALL leave the count unchanged.
REQ-019 When the buffer is full, no new request SHALL be issued; a pending ack always has space, because a request is launched only when space exists.
REQ-020 Flush SHALL clear the buffer in the same edge and take priority over a simultaneous push or pop.
REQ-021 Flush in REQ without ack SHALL go to DROP; DROP SHALL keep imem_req high until ack, then discard the data, suppress pc_advance, and go to IDLE.
REQ-022 Flush with ack in the same REQ cycle SHALL discard the data, suppress pc_advance, and go to IDLE.
REQ-023 instr_out, instr_pc and imm_out SHALL be combinational from the buffer head, and SHALL be 0 when the buffer is empty.
REQ-024 branch_out SHALL be instr_valid AND (instr_out[31:26]==BEQ_OPCODE).
REQ-025 The buffer pointers SHALL wrap modulo DEPTH.

Reset
REQ-026 Reset SHALL put the FSM in IDLE and empty the buffer.
REQ-027 Reset SHALL drive imem_req, pc_advance, instr_valid, branch_out and fetch_err to 0, and imem_addr, instr_out, instr_pc and imm_out to 0.
REQ-028 Reset asserted mid-request SHALL abandon the request without pc_advance; a later stray ack SHALL be ignored.

Configuration
REQ-029 With IFETCH_TIMEOUT_EN defined, a counter SHALL count REQ/DROP cycles; at TIMEOUT cycles without ack, the block SHALL drop imem_req, set fetch_err, and enter ERR.
REQ-030 ERR SHALL be left only by reset, and no requests SHALL be issued in ERR.
REQ-031 Without IFETCH_TIMEOUT_EN, the block SHALL wait indefinitely for ack, ERR SHALL be unreachable, fetch_err SHALL be tied 0, and the port SHALL remain.

Structure
REQ-032 Package ifetch_pkg SHALL hold the FSM state typedef, BEQ_OPCODE default, opcode field bounds [31:26] and immediate bounds [15:0].
REQ-033 The buffer SHALL be sub-module ifetch_fifo, parameterised by DEPTH and a 64-bit width (word plus PC), with push, pop, clear, full and empty.

Verification
REQ-034 The bench SHALL check: reset release, pc_in=104, ack 2 cycles after req, rdata=32'h1000_0064 -> imem_addr=104, one pc_advance pulse, instr_valid next cycle, imm_out=100, branch_out=1.
REQ-035 The bench SHALL check: instr_ready=0, 3 acks -> 2 entries buffered, third request not issued until one pop.
REQ-036 The bench SHALL check: flush while in REQ, ack 3 cycles later -> buffer empty, no pc_advance, FSM back to IDLE, next request uses new pc_in=200.
REQ-037 The bench SHALL check: with count=1, push and pop in the same cycle -> count stays 1 and order is preserved (instr_pc 104 then 108).
REQ-038 The bench SHALL check: IFETCH_TIMEOUT_EN with no ack for 16 cycles -> imem_req=0, fetch_err=1 held until reset; without the macro, req is still high at cycle 100.
REQ-039 The bench SHALL check: reset during REQ, then ack -> no push, no pc_advance, all outputs 0.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared types and field positions for the instruction fetch unit.
package ifetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DROP,
        ERR
    } fetch_state_t;

    localparam logic [5:0] BEQ_OPCODE_DEF = 6'b000100;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    // Buffer entry: {instruction word, PC it was fetched from}
    localparam int ENTRY_W = 64;

endpackage

// File: rtl/ifetch_fifo.sv
// Circular instruction buffer holding {word, pc} entries; head reads as zero when empty.
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = ENTRY_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // Explicit wrap so DEPTH need not be a power of two
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the empty flag masks stale contents.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: one outstanding memory read, buffered results, flush and PC handshake.
// Optional request timeout with sticky error is enabled by defining IFETCH_TIMEOUT_EN.
module instr_fetch
    import ifetch_pkg::*;
#(
    parameter int         DEPTH      = 2,
    parameter int         TIMEOUT    = 16,
    parameter logic [5:0] BEQ_OPCODE = BEQ_OPCODE_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    output logic        pc_advance,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [15:0] imm_out,
    output logic        branch_out,
    input  logic        flush,
    output logic        fetch_err
);

    fetch_state_t         state_q;
    fetch_state_t         state_d;
    logic [31:0]          addr_q;
    logic                 push;
    logic                 full;
    logic                 empty;
    logic [ENTRY_W-1:0]   head;
    logic                 timeout_hit;

`ifdef IFETCH_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    logic [TMR_W-1:0] timer_q;

    // Counts every cycle spent waiting in REQ or DROP for the current request
    always_ff @(posedge clk) begin
        if (reset || state_q == IDLE)
            timer_q <= '0;
        else if (state_q == REQ || state_q == DROP)
            timer_q <= timer_q + 1'b1;
    end

    assign timeout_hit = (timer_q == TMR_W'(TIMEOUT - 1));
    assign fetch_err   = (state_q == ERR);
`else
    assign timeout_hit = 1'b0;
    assign fetch_err   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && state_d == REQ) addr_q <= pc_in;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        push     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!full && !flush) state_d = REQ;
            end
            REQ: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    push    = !flush;
                    state_d = IDLE;
                end else if (timeout_hit) begin
                    state_d = ERR;
                end else if (flush) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                imem_req = 1'b1;
                if (imem_ack)         state_d = IDLE;
                else if (timeout_hit) state_d = ERR;
            end
            ERR:     state_d = ERR;
            default: state_d = IDLE;
        endcase
    end

    // A request abandoned by reset must not advance the PC
    assign pc_advance = push && !reset;
    assign imem_addr  = addr_q;

    ifetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (pc_advance),
        .pop   (instr_valid && instr_ready),
        .clear (flush),
        .wdata ({imem_rdata, addr_q}),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign instr_valid           = !empty;
    assign {instr_out, instr_pc} = head;
    assign imm_out               = instr_out[IMM_MSB:IMM_LSB];
    assign branch_out            = instr_valid && (instr_out[OPC_MSB:OPC_LSB] == BEQ_OPCODE);

endmodule
